// File: rtl/spi_tx_sequencer.sv
`default_nettype none
// ============================================================================
// spi_tx_sequencer : byte FIFO feeding a chip-select framed SPI byte writer
// Rev 1.0
// ============================================================================
module spi_tx_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int CS_SETUP   = 2,
   parameter int CS_HOLD    = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       wr_last,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       spi_start,
   output logic [7:0] spi_din,
   input  logic       spi_done,
   output logic       cs_n,
   output logic       busy,
   output logic       frame_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = 16;
   localparam logic [AW:0]   C_DEPTH      = (AW+1)'(FIFO_DEPTH);
   localparam logic [CW-1:0] C_SETUP_LAST = (CS_SETUP > 1) ? CW'(CS_SETUP - 2) : '0;
   localparam logic [CW-1:0] C_HOLD_LAST  = (CS_HOLD  > 1) ? CW'(CS_HOLD  - 2) : '0;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SETUP     = 3'd1,
      LOAD      = 3'd2,
      WAIT_DONE = 3'd3,
      WAIT_DATA = 3'd4,
      HOLD      = 3'd5
   } state_t;

   state_t        r_state;
   logic [8:0]    r_mem [FIFO_DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [CW-1:0] r_cnt;
   logic          r_last;

   logic          w_push;
   logic          w_pop;
   logic [AW:0]   w_count_next;
   logic [8:0]    w_head;

   // A write is judged against the FULL flag of the current cycle only.
   assign w_push = wr_en && !full;
   assign w_pop  = (r_state == LOAD);
   assign w_head = r_mem[r_rd_ptr];

   always_comb begin
      w_count_next = r_count;
      if (w_push && !w_pop)
         w_count_next = r_count + 1'b1;
      else if (!w_push && w_pop)
         w_count_next = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (w_push)
         r_mem[r_wr_ptr] <= {wr_last, wr_data};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
      end else begin
         if (w_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         if (wr_en && full)
            overflow <= 1'b1;
         r_count <= w_count_next;
         full    <= (w_count_next == C_DEPTH);
         empty   <= (w_count_next == '0);
      end
   end

   // SETUP and HOLD are skipped entirely when their counts are one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_last     <= 1'b0;
         cs_n       <= 1'b1;
         spi_start  <= 1'b0;
         spi_din    <= 8'h00;
         busy       <= 1'b0;
         frame_done <= 1'b0;
      end else begin
         spi_start  <= 1'b0;
         frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (!empty && !frame_done) begin
                  cs_n    <= 1'b0;
                  busy    <= 1'b1;
                  r_cnt   <= '0;
                  r_state <= (CS_SETUP > 1) ? SETUP : LOAD;
               end
            end
            SETUP: begin
               if (r_cnt == C_SETUP_LAST)
                  r_state <= LOAD;
               else
                  r_cnt <= r_cnt + 1'b1;
            end
            LOAD: begin
               spi_din   <= w_head[7:0];
               r_last    <= w_head[8];
               spi_start <= 1'b1;
               r_state   <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (spi_done) begin
                  if (r_last) begin
                     if (CS_HOLD > 1) begin
                        r_cnt   <= '0;
                        r_state <= HOLD;
                     end else begin
                        cs_n       <= 1'b1;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                        r_state    <= IDLE;
                     end
                  end else if (!empty) begin
                     r_state <= LOAD;
                  end else begin
                     r_state <= WAIT_DATA;
                  end
               end
            end
            WAIT_DATA: begin
               if (!empty)
                  r_state <= LOAD;
            end
            HOLD: begin
               if (r_cnt == C_HOLD_LAST) begin
                  cs_n       <= 1'b1;
                  busy       <= 1'b0;
                  frame_done <= 1'b1;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: begin
               cs_n    <= 1'b1;
               busy    <= 1'b0;
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_spi_tx_sequencer.sv
`default_nettype none
// tb_spi_tx_sequencer : randomized bench checked cycle-by-cycle against a queue-based frame model
module tb_spi_tx_sequencer;

   localparam int DEPTH = 8;
   localparam int SETUP = 2;
   localparam int HOLD  = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       wr_en = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic       wr_last = 1'b0;
   logic       spi_done = 1'b0;
   logic       full, empty, overflow, spi_start, cs_n, busy, frame_done;
   logic [7:0] spi_din;

   spi_tx_sequencer #(
      .FIFO_DEPTH(DEPTH),
      .CS_SETUP  (SETUP),
      .CS_HOLD   (HOLD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .wr_en     (wr_en),
      .wr_data   (wr_data),
      .wr_last   (wr_last),
      .full      (full),
      .empty     (empty),
      .overflow  (overflow),
      .spi_start (spi_start),
      .spi_din   (spi_din),
      .spi_done  (spi_done),
      .cs_n      (cs_n),
      .busy      (busy),
      .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state: queued bytes plus frame-level bookkeeping.
   logic [8:0] q[$];
   int         cyc = 0;
   int         sz1 = 0;
   int         sz2 = 0;
   int         ref_cyc = 0;
   int         end_cyc = -100;
   bit         m_active = 0, need = 0, outst = 0, exp_last = 0, m_ovf = 0, fd_prev = 0;
   bit         pend_wr = 0, pend_last = 0;
   logic [7:0] pend_data = 8'h00;
   logic [7:0] exp_din = 8'h00;
   bit         m_exp_start, m_exp_fd, m_acc;
   int         obs_starts = 0;
   int         obs_frames = 0;

   // Downstream byte writer: answers each start after a random delay.
   int dly_min = 1;
   int dly_max = 4;
   int dn_cnt = 0;
   bit spur_req = 0;

   initial forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
         dn_cnt   = 0;
         spi_done = 1'b0;
      end else begin
         spi_done = (dn_cnt == 1);
         if (dn_cnt > 0)
            dn_cnt--;
         if (spur_req) begin
            spi_done = 1'b1;
            spur_req = 0;
         end
         if (spi_start)
            dn_cnt = $urandom_range(dly_max, dly_min);
      end
   end

   initial forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
         q.delete();
         sz1 = 0; sz2 = 0; m_active = 0; need = 0; outst = 0; m_ovf = 0;
         fd_prev = 0; end_cyc = -100; exp_din = 8'h00; exp_last = 0;
         check_eq("rst_cs_n", cs_n, 1);
         check_eq("rst_empty", empty, 1);
         check_eq("rst_full", full, 0);
         check_eq("rst_overflow", overflow, 0);
         check_eq("rst_busy", busy, 0);
         check_eq("rst_start", spi_start, 0);
         check_eq("rst_din", spi_din, 0);
         check_eq("rst_frame_done", frame_done, 0);
      end else begin
         m_acc = pend_wr && (q.size() < DEPTH);
         if (pend_wr && !m_acc)
            m_ovf = 1;
         // Next byte goes out two cycles after both the previous done and data availability.
         m_exp_start = need && (cyc - 2 >= ref_cyc) && (sz2 > 0) && (q.size() > 0);
         if (m_exp_start) begin
            exp_din  = q[0][7:0];
            exp_last = q[0][8];
            void'(q.pop_front());
            need  = 0;
            outst = 1;
         end
         if (m_acc)
            q.push_back({pend_last, pend_data});
         if (!m_active && sz1 > 0 && !fd_prev) begin
            m_active = 1;
            need     = 1;
            ref_cyc  = cyc + SETUP - 2;
         end
         if (spi_done && outst) begin
            outst = 0;
            if (exp_last) begin
               end_cyc = cyc + HOLD;
            end else begin
               need    = 1;
               ref_cyc = cyc;
            end
         end
         m_exp_fd = (cyc == end_cyc);
         if (m_exp_fd) begin
            m_active = 0;
            end_cyc  = -100;
         end
         if (spi_start)  obs_starts++;
         if (frame_done) obs_frames++;
         check_eq("cs_n", cs_n, !m_active);
         check_eq("busy", busy, m_active);
         check_eq("spi_start", spi_start, m_exp_start);
         check_eq("spi_din", spi_din, exp_din);
         check_eq("frame_done", frame_done, m_exp_fd);
         check_eq("full", full, q.size() == DEPTH);
         check_eq("empty", empty, q.size() == 0);
         check_eq("overflow", overflow, m_ovf);
         sz2     = sz1;
         sz1     = q.size();
         fd_prev = m_exp_fd;
      end
      pend_wr   = rst_n && wr_en;
      pend_data = wr_data;
      pend_last = wr_last;
   end

   task automatic wr(input logic [7:0] d, input logic l);
      @(posedge clk);
      #2;
      wr_en   = 1'b1;
      wr_data = d;
      wr_last = l;
   endtask

   task automatic stop();
      @(posedge clk);
      #2;
      wr_en   = 1'b0;
      wr_last = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      repeat (4) @(posedge clk);
      while ((m_active || q.size() != 0 || outst) && n < 4000) begin
         @(posedge clk);
         n++;
      end
      check_eq({tag, "_timeout"}, (n < 4000), 1);
      repeat (3) @(posedge clk);
   endtask

   int s0, f0;

   initial begin
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;

      // Spurious done while idle must not start anything.
      repeat (3) @(posedge clk);
      #2;
      spur_req = 1;
      repeat (6) @(posedge clk);
      check_eq("idle_spur_cs_n", cs_n, 1);
      check_eq("idle_spur_frames", obs_frames, 0);

      // Single byte A5, fixed 20-cycle downstream, spurious done during SETUP.
      dly_min = 20; dly_max = 20;
      s0 = obs_starts; f0 = obs_frames;
      wr(8'hA5, 1'b1);
      stop();
      spur_req = 1;
      wait_idle("single");
      check_eq("single_starts", obs_starts - s0, 1);
      check_eq("single_frames", obs_frames - f0, 1);

      // Three-byte frame.
      dly_min = 4; dly_max = 9;
      s0 = obs_starts; f0 = obs_frames;
      wr(8'h01, 1'b0);
      wr(8'h02, 1'b0);
      wr(8'h03, 1'b1);
      stop();
      wait_idle("three");
      check_eq("three_starts", obs_starts - s0, 3);
      check_eq("three_frames", obs_frames - f0, 1);

      // Fill the FIFO behind a slow outstanding byte; the ninth write is dropped.
      dly_min = 60; dly_max = 60;
      s0 = obs_starts; f0 = obs_frames;
      wr(8'h70, 1'b0);
      stop();
      repeat (8) @(posedge clk);
      for (int i = 0; i < 9; i++)
         wr(8'h80 + 8'(i), (i == 7));
      stop();
      check_eq("fill_full", full, 1);
      check_eq("fill_overflow", overflow, 1);
      wait_idle("fill");
      check_eq("fill_starts", obs_starts - s0, 9);
      check_eq("fill_frames", obs_frames - f0, 1);

      // Underrun: frame stays open until the last byte arrives.
      dly_min = 3; dly_max = 6;
      s0 = obs_starts; f0 = obs_frames;
      wr(8'h11, 1'b0);
      stop();
      repeat (50) @(posedge clk);
      check_eq("underrun_cs_low", cs_n, 0);
      check_eq("underrun_busy", busy, 1);
      wr(8'h22, 1'b1);
      stop();
      wait_idle("underrun");
      check_eq("underrun_starts", obs_starts - s0, 2);
      check_eq("underrun_frames", obs_frames - f0, 1);

      // Reset while a byte is outstanding and three more are queued.
      dly_min = 30; dly_max = 30;
      wr(8'h31, 1'b0);
      wr(8'h32, 1'b0);
      wr(8'h33, 1'b0);
      wr(8'h34, 1'b1);
      stop();
      repeat (8) @(posedge clk);
      #2;
      check_eq("prerst_empty", empty, 0);
      check_eq("prerst_cs_n", cs_n, 0);
      rst_n = 1'b0;
      #1;
      check_eq("async_rst_cs_n", cs_n, 1);
      check_eq("async_rst_empty", empty, 1);
      check_eq("async_rst_busy", busy, 0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      s0 = obs_starts; f0 = obs_frames;
      repeat (40) @(posedge clk);
      check_eq("postrst_starts", obs_starts - s0, 0);
      dly_min = 2; dly_max = 5;
      wr(8'h5A, 1'b1);
      stop();
      wait_idle("postrst");
      check_eq("postrst_frames", obs_frames - f0, 1);

      // Random traffic: random bytes, frame boundaries, gaps and downstream delays.
      dly_min = 1; dly_max = 8;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) != 0)
            wr(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
         else
            stop();
      end
      stop();
      for (int n = 0; n < 2000 && q.size() >= DEPTH - 1; n++)
         @(posedge clk);
      wr(8'hFF, 1'b1);
      stop();
      wait_idle("random");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
